pause_dim_ctrl: RTL and testbench
=================================

PAUSE_DIM_CTRL -- requirements
Module: pause_dim_ctrl

Interface
REQ-001 Parameter RW, default 3, red channel width in bits.
REQ-002 Parameter GW, default 3, green channel width in bits.
REQ-003 Parameter BW, default 2, blue channel width in bits.
REQ-004 Parameter NREQ, default 2, number of external pause request inputs (>=1).
REQ-005 Parameter TICK_CYCLES, default 18000000, clk_sys cycles per dim-timer tick (>=2).
REQ-006 Parameter DIM_TICKS, default 10, ticks of continuous pause before fading starts (>=1).
REQ-007 Parameter DIM_MAX, default 1, final dim level as right-shift amount (1..min(RW,GW,BW)).
REQ-008 clk_sys  in  1  system clock; all logic on rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 user_button  in  1  pause button level, already synchronous to clk_sys.
REQ-011 pause_request  in  NREQ  level pause requests (hiscore, loaders), any bit high pauses.
REQ-012 osd_status  in  1  OSD open level.
REQ-013 options  in  2  bit0 = pause while OSD open enable, bit1 = dim enable; both active-high.
REQ-014 r_in / g_in / b_in  in  RW / GW / BW  pixel colour in.
REQ-015 rgb_out  out  RW+GW+BW  {r,g,b} after dimming, registered.
REQ-016 pause_cpu  out  1  registered CPU halt.
REQ-017 dim_video  out  1  high when dim level is non-zero.
REQ-018 dim_level  out  clog2(DIM_MAX+1)  current right-shift amount.

Function
REQ-019 Register user_button and detect a 0->1 edge; each edge toggles internal user_pause.
REQ-020 Pause source = user_pause | (|pause_request) | (options[0] & osd_status).
REQ-021 pause_cpu shall equal the pause source delayed by exactly one clk_sys edge.
REQ-022 FSM states: RUN, PAUSED, FADING, DIMMED.
REQ-023 RUN: when pause source is high go PAUSED; prescaler and tick counter cleared; level 0.
REQ-024 Prescaler counts 0..TICK_CYCLES-1 in PAUSED/FADING only; tick is the cycle where it equals TICK_CYCLES-1, then it wraps to 0.
REQ-025 PAUSED: on tick, if tick counter == DIM_TICKS-1 go FADING (or DIMMED if DIM_MAX==1) with level 1; else tick counter +1.
REQ-026 FADING: on tick, level +1; when the new level equals DIM_MAX go DIMMED.
REQ-027 DIMMED: level held at DIM_MAX; counters frozen.
REQ-028 From any non-RUN state, pause source low goes RUN with level 0 and counters cleared on the same edge.
REQ-029 options[1] low in PAUSED/FADING/DIMMED: level 0, counters cleared, state PAUSED; timer does not advance while low.
REQ-030 Additional sources asserting while already paused shall not restart the timer.
REQ-031 rgb_out channel = input channel logically shifted right by level, registered one cycle after r_in/g_in/b_in; level applied is the registered value at that edge.
REQ-032 dim_video = (level != 0); dim_level = level.
REQ-033 Button edge and pause source dropping on same cycle: user_pause toggle first, then REQ-028 evaluated on the next edge with the new source.

Reset
REQ-034 Reset forces RUN, user_pause 0, level 0, prescaler 0, tick counter 0, button register 0.
REQ-035 During reset: pause_cpu 0, dim_video 0, dim_level 0, rgb_out 0.
REQ-036 Reset asserted mid-fade returns all outputs to reset values on the next edge regardless of inputs; a button held high through reset release shall not toggle.

Verification (bench: TICK_CYCLES=4, DIM_TICKS=3, DIM_MAX=2, RW=GW=3, BW=2)
REQ-037 Button pulse 0->1 at edge N -> pause_cpu high from edge N+2; second pulse clears it two edges later.
REQ-038 Hold pause_request[0]=1, options=2'b10, r=7,g=6,b=3 -> level 0 for 12 cycles in PAUSED, level 1 (rgb 3,3,1) at 12, level 2 (rgb 1,1,0) at 16, DIMMED thereafter.
REQ-039 options=2'b01, osd_status=1 for 40 cycles -> pause_cpu 1, dim_video stays 0; options=2'b00 -> osd_status ignored, pause_cpu 0.
REQ-040 In DIMMED drop all sources -> next edge RUN, dim_level 0, rgb_out passes input unshifted one cycle later.
REQ-041 Reset pulse at cycle 14 of fade with button held high -> all outputs 0, no toggle after release.

Source files
------------

// File: rtl/pause_dim_ctrl_if.sv
// Pause/dim control bus.
// Groups the pause inputs, the pixel stream in and the control/pixel results
// out of pause_dim_ctrl.
//   user_button   : pause button level (already synchronous to clk_sys)
//   pause_request : level pause requests, any bit high pauses
//   osd_status    : OSD open level
//   options       : bit0 pause while OSD open, bit1 dim enable
//   r_in/g_in/b_in: pixel colour in
//   rgb_out       : {r,g,b} after dimming, registered
//   pause_cpu     : registered CPU halt
//   dim_video     : dim level is non-zero
//   dim_level     : current right-shift amount
// master = the side driving pause inputs and pixels, slave = pause_dim_ctrl.
interface pause_dim_ctrl_if #(
  parameter int RW      = 3,
  parameter int GW      = 3,
  parameter int BW      = 2,
  parameter int NREQ    = 2,
  parameter int DIM_MAX = 1
);
  localparam int LW = $clog2(DIM_MAX + 1);

  logic                   user_button;
  logic [NREQ-1:0]        pause_request;
  logic                   osd_status;
  logic [1:0]             options;
  logic [RW-1:0]          r_in;
  logic [GW-1:0]          g_in;
  logic [BW-1:0]          b_in;
  logic [RW+GW+BW-1:0]    rgb_out;
  logic                   pause_cpu;
  logic                   dim_video;
  logic [LW-1:0]          dim_level;

  modport master (
    output user_button, pause_request, osd_status, options, r_in, g_in, b_in,
    input  rgb_out, pause_cpu, dim_video, dim_level
  );

  modport slave (
    input  user_button, pause_request, osd_status, options, r_in, g_in, b_in,
    output rgb_out, pause_cpu, dim_video, dim_level
  );
endinterface

// File: rtl/pause_dim_ctrl.sv
// Pause and screen-dim controller.
// Combines a toggling pause button, external pause requests and an optional
// OSD pause into one CPU halt. While paused, a prescaled timer waits
// DIM_TICKS ticks and then steps the video dim level (a right shift of each
// colour channel) from 1 up to DIM_MAX.
// Ports:
//   clk_sys : system clock, rising edge
//   reset   : synchronous, active-high
//   bus     : pause_dim_ctrl_if slave (pause inputs, pixels, results)
module pause_dim_ctrl #(
  parameter int RW          = 3,
  parameter int GW          = 3,
  parameter int BW          = 2,
  parameter int NREQ        = 2,
  parameter int TICK_CYCLES = 18000000,
  parameter int DIM_TICKS   = 10,
  parameter int DIM_MAX     = 1
) (
  input logic              clk_sys,
  input logic              reset,
  pause_dim_ctrl_if.slave  bus
);

  localparam int LW = $clog2(DIM_MAX + 1);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam int TW = $clog2(DIM_TICKS + 1);

  localparam logic [LW-1:0] LVL_ZERO   = '0;
  localparam logic [LW-1:0] LVL_ONE    = LW'(1);
  localparam logic [LW-1:0] LVL_MAX    = LW'(DIM_MAX);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE   = TW'(1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(DIM_TICKS - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    FADING = 2'd2,
    DIMMED = 2'd3
  } state_t;

  state_t          state;
  logic [LW-1:0]   level;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   tick_cnt;
  logic            pause_cpu_q;

  logic            btn_q;
  logic            btn_armed;
  logic            user_pause;
  logic            btn_rise;
  logic            pause_src;
  logic            tick;
  logic [LW-1:0]   level_nxt;

  logic [RW-1:0]   r_p1;
  logic [GW-1:0]   g_p1;
  logic [BW-1:0]   b_p1;

  // btn_armed stays low for the first cycle after reset so that a button
  // already held high when reset is released is loaded into btn_q without
  // being seen as a fresh press.
  assign btn_rise  = btn_armed & bus.user_button & ~btn_q;
  assign pause_src = user_pause | (|bus.pause_request) |
                     (bus.options[0] & bus.osd_status);
  assign tick      = (presc == PRESC_LAST);
  assign level_nxt = level + LVL_ONE;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_q      <= 1'b0;
      btn_armed  <= 1'b0;
      user_pause <= 1'b0;
    end else begin
      btn_q     <= bus.user_button;
      btn_armed <= 1'b1;
      if (btn_rise) begin
        user_pause <= ~user_pause;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= RUN;
      level       <= LVL_ZERO;
      presc       <= '0;
      tick_cnt    <= '0;
      pause_cpu_q <= 1'b0;
    end else begin
      pause_cpu_q <= pause_src;
      case (state)
        RUN: begin
          level    <= LVL_ZERO;
          presc    <= '0;
          tick_cnt <= '0;
          if (pause_src) begin
            state <= PAUSED;
          end
        end
        default: begin
          if (!pause_src) begin
            state    <= RUN;
            level    <= LVL_ZERO;
            presc    <= '0;
            tick_cnt <= '0;
          end else if (!bus.options[1]) begin
            // Dimming disabled: hold the timer at its start point so that
            // re-enabling begins a full wait, not a partial one.
            state    <= PAUSED;
            level    <= LVL_ZERO;
            presc    <= '0;
            tick_cnt <= '0;
          end else if (state == DIMMED) begin
            level <= LVL_MAX;
          end else begin
            presc <= tick ? '0 : presc + PRESC_ONE;
            if (tick) begin
              if (state == PAUSED) begin
                if (tick_cnt == TICK_LAST) begin
                  level <= LVL_ONE;
                  state <= (LVL_ONE == LVL_MAX) ? DIMMED : FADING;
                end else begin
                  tick_cnt <= tick_cnt + TICK_ONE;
                end
              end else begin
                level <= level_nxt;
                if (level_nxt == LVL_MAX) begin
                  state <= DIMMED;
                end
              end
            end
          end
        end
      endcase
    end
  end

  // ---- pixel stage p1: shift by the level registered at this edge ----
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_p1 <= '0;
      g_p1 <= '0;
      b_p1 <= '0;
    end else begin
      r_p1 <= bus.r_in >> level;
      g_p1 <= bus.g_in >> level;
      b_p1 <= bus.b_in >> level;
    end
  end

  assign bus.rgb_out   = {r_p1, g_p1, b_p1};
  assign bus.pause_cpu = pause_cpu_q;
  assign bus.dim_video = (level != LVL_ZERO);
  assign bus.dim_level = level;

endmodule

// File: tb/tb_pause_dim_ctrl.sv
module tb_pause_dim_ctrl;
  localparam int RW          = 3;
  localparam int GW          = 3;
  localparam int BW          = 2;
  localparam int NREQ        = 2;
  localparam int TICK_CYCLES = 4;
  localparam int DIM_TICKS   = 3;
  localparam int DIM_MAX     = 2;

  logic clk_sys = 1'b0;
  logic reset;

  always #5 clk_sys = ~clk_sys;

  pause_dim_ctrl_if #(.RW(RW), .GW(GW), .BW(BW), .NREQ(NREQ), .DIM_MAX(DIM_MAX)) bus ();

  pause_dim_ctrl #(
    .RW(RW), .GW(GW), .BW(BW), .NREQ(NREQ),
    .TICK_CYCLES(TICK_CYCLES), .DIM_TICKS(DIM_TICKS), .DIM_MAX(DIM_MAX)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct packed {
    logic       pcpu;
    logic       dimv;
    logic [1:0] lvl;
    logic [7:0] rgb;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // r=7,g=6,b=3 seen through dim levels 0, 1 and 2
  logic [7:0] shade_tbl [3] = '{8'b111_110_11, 8'b011_011_01, 8'b001_001_00};

  function automatic obs_t mk(logic pcpu, logic [1:0] lvl, logic [7:0] rgb);
    obs_t o;
    o.pcpu = pcpu;
    o.dimv = (lvl != 2'd0);
    o.lvl  = lvl;
    o.rgb  = rgb;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.pcpu = bus.pause_cpu;
    o.dimv = bus.dim_video;
    o.lvl  = bus.dim_level;
    o.rgb  = bus.rgb_out;
    return o;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_pix(logic [2:0] r, logic [2:0] g, logic [1:0] b);
    bus.r_in = r;
    bus.g_in = g;
    bus.b_in = b;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    reset = 1'b1;
    bus.user_button   = 1'b0;
    bus.pause_request = 2'b11;
    bus.osd_status    = 1'b1;
    bus.options       = 2'b11;
    set_pix(3'd7, 3'd6, 2'd3);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        reset = 1'b0;
        bus.pause_request = 2'b00;
        bus.osd_status    = 1'b0;
        bus.options       = 2'b10;
        set_pix(3'd0, 3'd0, 2'd0);
      end
      exp_q.push_back(mk(1'b0, 2'd0, 8'h00));
      step();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got {pcpu,dim,lvl,rgb}=%b need %b", i, got, exp);
      end
    end
  endtask

  task automatic test_button();
    obs_t got, exp;
    logic btn_pat  [10] = '{0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    logic pcpu_pat [10] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    set_pix(3'd5, 3'd2, 2'd1);
    for (int e = 0; e < 10; e++) begin
      bus.user_button = btn_pat[e];
      exp_q.push_back(mk(pcpu_pat[e], 2'd0, 8'b101_010_01));
      step();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL button edge=%0d got %b need %b", e, got, exp);
      end
    end
  endtask

  task automatic test_fade();
    obs_t got, exp;
    int lvl, prev;
    bus.pause_request = 2'b01;
    bus.options       = 2'b10;
    set_pix(3'd7, 3'd6, 2'd3);
    prev = 0;
    for (int e = 0; e < 25; e++) begin
      lvl = (e >= 16) ? 2 : (e >= 12) ? 1 : 0;
      exp_q.push_back(mk(1'b1, 2'(lvl), shade_tbl[prev]));
      step();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fade edge=%0d got %b need %b", e, got, exp);
      end
      prev = lvl;
      // a second source joining mid-pause must not restart the timer
      if (e == 6) bus.pause_request = 2'b11;
    end
  endtask

  task automatic test_release();
    obs_t got, exp;
    int rgb_idx [3] = '{2, 0, 0};
    bus.pause_request = 2'b00;
    for (int e = 0; e < 3; e++) begin
      exp_q.push_back(mk(1'b0, 2'd0, shade_tbl[rgb_idx[e]]));
      step();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL release edge=%0d got %b need %b", e, got, exp);
      end
    end
  endtask

  task automatic test_osd();
    obs_t got, exp;
    bus.options    = 2'b01;
    bus.osd_status = 1'b1;
    set_pix(3'd6, 3'd5, 2'd2);
    for (int e = 0; e < 45; e++) begin
      if (e == 40) bus.options = 2'b00;
      exp_q.push_back(mk((e < 40) ? 1'b1 : 1'b0, 2'd0, 8'b110_101_10));
      step();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL osd edge=%0d got %b need %b", e, got, exp);
      end
    end
    bus.osd_status = 1'b0;
  endtask

  task automatic test_dim_disable();
    obs_t got, exp;
    int lvl, prev;
    bus.pause_request = 2'b01;
    bus.options       = 2'b10;
    set_pix(3'd7, 3'd6, 2'd3);
    prev = 0;
    for (int e = 0; e < 31; e++) begin
      if (e == 14) bus.options = 2'b00;
      if (e == 18) bus.options = 2'b10;
      lvl = (e < 12) ? 0 : (e < 14) ? 1 : (e < 29) ? 0 : 1;
      exp_q.push_back(mk(1'b1, 2'(lvl), shade_tbl[prev]));
      step();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL dim_disable edge=%0d got %b need %b", e, got, exp);
      end
      prev = lvl;
    end
  endtask

  task automatic test_reset_mid_fade();
    obs_t got, exp;
    int lvl, prev;
    logic pc;
    logic [7:0] rgb;
    bus.pause_request = 2'b00;
    step();
    step();
    bus.user_button = 1'b1;
    bus.options     = 2'b10;
    prev = 0;
    for (int e = 0; e < 27; e++) begin
      if (e == 15) begin
        reset = 1'b1;
        bus.pause_request = 2'b11;
        bus.osd_status    = 1'b1;
        bus.options       = 2'b11;
      end
      if (e == 17) begin
        reset = 1'b0;
        bus.pause_request = 2'b00;
        bus.osd_status    = 1'b0;
        bus.options       = 2'b10;
      end
      if (e == 22) bus.user_button = 1'b0;
      if (e == 25) bus.user_button = 1'b1;
      if (e < 15) begin
        lvl = (e >= 13) ? 1 : 0;
        pc  = (e >= 1);
        rgb = shade_tbl[prev];
      end else if (e < 17) begin
        lvl = 0;
        pc  = 1'b0;
        rgb = 8'h00;
      end else begin
        lvl = 0;
        pc  = (e == 26);
        rgb = shade_tbl[0];
      end
      exp_q.push_back(mk(pc, 2'(lvl), rgb));
      step();
      got = observe();
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset_mid_fade edge=%0d got %b need %b", e, got, exp);
      end
      prev = lvl;
    end
  endtask

  initial begin
    test_reset();
    test_button();
    test_fade();
    test_release();
    test_osd();
    test_dim_disable();
    test_reset_mid_fade();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d need 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
